button_scheduler: RTL

Front-end controller that turns N independent push-buttons into a serialized stream of button-event commands for one shared downstream consumer (mode/counter control logic). Each button has a press-then-release detector. Completed presses are latched as pending requests and granted one at a time, in round-robin order, over a valid/ready handshake. Presses that arrive while an earlier one from the same button is still pending are counted as overruns.

---
 rtl/button_pkg.sv | 20 ++
 rtl/button_scheduler_if.sv | 16 +
 rtl/button_edge.sv | 39 +++
 rtl/button_scheduler.sv | 119 +++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types for the button scheduler.
//   DEFAULT_N   : default number of buttons
//   det_state_t : per-button press/release detector states
//   arb_state_t : arbiter states
package button_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    REL  = 2'd2
  } det_state_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/button_scheduler_if.sv
// Command handshake between the scheduler (master) and its consumer (slave).
//   cmd_valid_o : command offered
//   cmd_id_o    : button index of the offered press
//   cmd_ready_i : consumer accepts the command this cycle
interface button_scheduler_if #(
  parameter int IDW = 2
) ();

  logic           cmd_valid_o;
  logic [IDW-1:0] cmd_id_o;
  logic           cmd_ready_i;

  modport master (output cmd_valid_o, output cmd_id_o, input cmd_ready_i);
  modport slave  (input cmd_valid_o, input cmd_id_o, output cmd_ready_i);

endinterface

// File: rtl/button_edge.sv
// Press-then-release detector for one button.
//   clk, rst : clock, async active-low reset
//   b_i      : synchronized button level, 1 = pressed
//   press_o  : one-cycle pulse after a complete press/release
//
// state | meaning
// IDLE  | waiting for the button to go down
// HELD  | button down, waiting for release
// REL   | release seen; press_o high for this one cycle
module button_edge
  import button_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic b_i,
  output logic press_o
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (b_i)  state_d = HELD;
      HELD:    if (!b_i) state_d = REL;
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state flop, so the pulse is glitch-free.
  assign press_o = (state_q == REL);

endmodule

// File: rtl/button_scheduler.sv
// Serializes completed button presses into one command stream.
//   clk, rst   : clock, async active-low reset
//   b_i        : synchronized button levels
//   cmd        : valid/ready command port (master side)
//   pending_o  : per-button pending request flags
//   overrun_o  : sticky per-button overrun flags
//   clr_ovr_i  : synchronous clear of all overrun flags
//
// state     | meaning
// ARB_IDLE  | looking for a pending request to capture
// ARB_OFFER | command offered, held until cmd_ready_i
module button_scheduler
  import button_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            b_i,
  button_scheduler_if.master      cmd,
  output logic [N-1:0]            pending_o,
  output logic [N-1:0]            overrun_o,
  input  logic                    clr_ovr_i
);

  logic [N-1:0]   press;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  arb_state_t     arb_q, arb_d;
  logic           cap;
  logic [IDW-1:0] cap_id;
  logic [N-1:0]   cap_mask;

  for (genvar k = 0; k < N; k++) begin : g_det
    button_edge u_edge (
      .clk     (clk),
      .rst     (rst),
      .b_i     (b_i[k]),
      .press_o (press[k])
    );
  end

  // First set bit starting at ptr, wrapping; the doubled vector makes the
  // rotation a plain shift.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [IDW-1:0] ptr);
    logic [2*N-1:0] rot;
    logic           found;
    int             idx;
    rr_pick = '0;
    found   = 1'b0;
    rot     = {req, req} >> ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = int'(ptr) + i;
        if (idx >= N) idx = idx - N;
        rr_pick = IDW'(idx);
      end
    end
  endfunction

  assign cap      = (arb_q == ARB_IDLE) && (|pending_q);
  assign cap_id   = rr_pick(pending_q, ptr_q);
  assign cap_mask = cap ? ({{(N-1){1'b0}}, 1'b1} << cap_id) : '0;

  always_comb begin
    // A new press beats a same-edge capture; a press onto an already
    // pending, uncaptured request is dropped and flagged.
    pending_d = (pending_q & ~cap_mask) | press;
    overrun_d = (press & pending_q & ~cap_mask) | (clr_ovr_i ? '0 : overrun_q);
  end

  always_comb begin
    arb_d = arb_q;
    id_d  = id_q;
    ptr_d = ptr_q;
    case (arb_q)
      ARB_IDLE: begin
        if (cap) begin
          id_d  = cap_id;
          arb_d = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (cmd.cmd_ready_i) begin
          ptr_d = (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
          arb_d = ARB_IDLE;
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_q     <= ARB_IDLE;
      id_q      <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      arb_q     <= arb_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd.cmd_valid_o = (arb_q == ARB_OFFER);
  assign cmd.cmd_id_o    = id_q;
  assign pending_o       = pending_q;
  assign overrun_o       = overrun_q;

endmodule
